// File: rtl/ex_muldiv.sv
// EX-stage HI/LO unit: single-cycle MULT/MULTU/MTHI/MTLO commit and a
// 32-step restoring divider (DIV/DIVU) that stalls the pipeline while busy.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        ex_adv_i,
  input  logic        annul_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o,
  output logic        busy_o
);

  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {IDLE, DIV_BUSY, DIV_DONE} state_t;

  state_t      state, state_n;
  logic [31:0] hi_q, lo_q;
  logic [31:0] rem_q, quo_q, dsr_q, dvd_raw_q;
  logic        qsign_q, dsign_q;
  logic [5:0]  cnt_q;

  logic        is_div, is_sdiv, start_div;
  logic [31:0] dvd_abs, dsr_abs;
  logic [63:0] prod_s, prod_u;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] rem_n, quo_n;
  logic        hi_we, lo_we;
  logic [31:0] hi_d, lo_d;

  assign hi_o = hi_q;
  assign lo_o = lo_q;
  assign busy_o = (state == DIV_BUSY) && !rst;

  assign is_sdiv   = (aluop_i == EXE_DIV_OP);
  assign is_div    = is_sdiv || (aluop_i == EXE_DIVU_OP);
  assign start_div = (state == IDLE) && is_div && !annul_i;

  assign dvd_abs = (is_sdiv && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
  assign dsr_abs = (is_sdiv && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;

  assign prod_s = {{32{reg1_i[31]}}, reg1_i} * {{32{reg2_i[31]}}, reg2_i};
  assign prod_u = {32'd0, reg1_i} * {32'd0, reg2_i};

  // Remainder stays below the divisor, so the trial subtraction fits in 32 bits.
  assign shifted = {rem_q, quo_q[31]};
  assign ge      = (shifted >= {1'b0, dsr_q});
  assign rem_n   = ge ? (shifted[31:0] - dsr_q) : shifted[31:0];
  assign quo_n   = {quo_q[30:0], ge};

  always_comb begin
    state_n    = state;
    stallreq_o = 1'b0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    if (rst || annul_i) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (is_div) begin
            stallreq_o = 1'b1;
            state_n    = DIV_BUSY;
          end else if (ex_adv_i) begin
            case (aluop_i)
              EXE_MULT_OP:  begin hi_we = 1'b1; lo_we = 1'b1; hi_d = prod_s[63:32]; lo_d = prod_s[31:0]; end
              EXE_MULTU_OP: begin hi_we = 1'b1; lo_we = 1'b1; hi_d = prod_u[63:32]; lo_d = prod_u[31:0]; end
              EXE_MTHI_OP:  begin hi_we = 1'b1; hi_d = reg1_i; end
              EXE_MTLO_OP:  begin lo_we = 1'b1; lo_d = reg1_i; end
              default: ;
            endcase
          end
        end
        DIV_BUSY: begin
          stallreq_o = 1'b1;
          if (dsr_q == '0) begin
            hi_we   = 1'b1;
            lo_we   = 1'b1;
            hi_d    = dvd_raw_q;
            lo_d    = '1;
            state_n = DIV_DONE;
          end else if (cnt_q == 6'd31) begin
            hi_we   = 1'b1;
            lo_we   = 1'b1;
            hi_d    = dsign_q ? (~rem_n + 32'd1) : rem_n;
            lo_d    = qsign_q ? (~quo_n + 32'd1) : quo_n;
            state_n = DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (ex_adv_i) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_d;
      if (lo_we) lo_q <= lo_d;
      if (start_div) begin
        rem_q     <= '0;
        quo_q     <= dvd_abs;
        dsr_q     <= dsr_abs;
        dvd_raw_q <= reg1_i;
        qsign_q   <= is_sdiv && (reg1_i[31] ^ reg2_i[31]);
        dsign_q   <= is_sdiv && reg1_i[31];
        cnt_q     <= '0;
      end else if (state == DIV_BUSY) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= cnt_q + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Table-driven bench for ex_muldiv with a HI/LO scoreboard queue and
// hand-written annul/reset sequences during a division.
module tb_ex_muldiv;

  localparam logic [7:0] NOP   = 8'h00;
  localparam logic [7:0] OR_OP = 8'b0010_0101;
  localparam logic [7:0] MTHI  = 8'b0001_0001;
  localparam logic [7:0] MTLO  = 8'b0001_0011;
  localparam logic [7:0] MULT  = 8'b0001_1000;
  localparam logic [7:0] MULTU = 8'b0001_1001;
  localparam logic [7:0] DIV   = 8'b0001_1010;
  localparam logic [7:0] DIVU  = 8'b0001_1011;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [31:0] reg1_i, reg2_i;
  logic        ex_adv_i, annul_i;
  logic [31:0] hi_o, lo_o;
  logic        stallreq_o, busy_o;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
    .ex_adv_i(ex_adv_i), .annul_i(annul_i), .hi_o(hi_o), .lo_o(lo_o),
    .stallreq_o(stallreq_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [7:0]  op;
    logic [31:0] r1, r2, hi, lo;
    int          stall;
    int          hold;
    bit          scramble;
  } vec_t;

  vec_t        vecs[15];
  logic [63:0] sb[$];
  int          passed = 0;
  int          total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic sb_check(input string name);
    logic [63:0] e;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty, got %h expected an entry", name, {hi_o, lo_o});
    end else begin
      e = sb.pop_front();
      chk(name, {hi_o, lo_o}, e);
    end
  endtask

  task automatic do_op(input vec_t v, input int idx);
    int n;
    @(negedge clk);
    aluop_i = v.op; reg1_i = v.r1; reg2_i = v.r2; ex_adv_i = 1'b0; annul_i = 1'b0;
    sb.push_back({v.hi, v.lo});
    #1;
    n = 0;
    while (stallreq_o && n < 100) begin
      if (n <= 1) chk($sformatf("busy[%0d].%0d", idx, n), {63'd0, busy_o}, {63'd0, (n == 1)});
      n++;
      @(negedge clk);
      if (v.scramble) begin
        aluop_i = MULT; reg1_i = $urandom; reg2_i = $urandom;
      end
      #1;
    end
    chk($sformatf("stall_cycles[%0d]", idx), 64'(n), 64'(v.stall));
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk); #1;
      chk($sformatf("hold_idle[%0d].%0d", idx, h), {62'd0, stallreq_o, busy_o}, 64'd0);
      chk($sformatf("hold_hilo[%0d].%0d", idx, h), {hi_o, lo_o}, {v.hi, v.lo});
    end
    ex_adv_i = 1'b1;
    @(negedge clk);
    ex_adv_i = 1'b0; aluop_i = NOP;
    #1;
    sb_check($sformatf("result[%0d]", idx));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] mhi, mlo;
    vec_t v;

    rst = 1'b1; aluop_i = DIVU; reg1_i = 32'd100; reg2_i = 32'd7;
    ex_adv_i = 1'b1; annul_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_stall_busy", {62'd0, stallreq_o, busy_o}, 64'd0);
    chk("reset_hilo", {hi_o, lo_o}, 64'd0);
    rst = 1'b0; aluop_i = NOP; ex_adv_i = 1'b0;

    //          op     r1            r2            hi            lo            stall hold scr
    vecs[0]  = '{MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 0,  0, 0};
    vecs[1]  = '{MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 0,  0, 0};
    vecs[2]  = '{MTHI,  32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 32'hFFFFFFFA, 0,  0, 0};
    vecs[3]  = '{MTLO,  32'h13579BDF, 32'h0,        32'hA5A5A5A5, 32'h13579BDF, 0,  0, 0};
    vecs[4]  = '{OR_OP, 32'h11111111, 32'h22222222, 32'hA5A5A5A5, 32'h13579BDF, 0,  0, 0};
    vecs[5]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33, 5, 0};
    vecs[6]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 0, 1};
    vecs[7]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 0, 0};
    vecs[8]  = '{DIV,   32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF, 2,  2, 0};
    vecs[9]  = '{DIVU,  32'd15,       32'd4,        32'd3,        32'd3,        33, 5, 0};
    vecs[10] = '{DIVU,  32'd9,        32'd3,        32'd0,        32'd3,        33, 0, 0};
    vecs[11] = '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33, 0, 0};
    vecs[12] = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        0,  0, 0};
    vecs[13] = '{DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 33, 0, 0};
    vecs[14] = '{DIVU,  32'd5,        32'hFFFFFFFF, 32'd5,        32'd0,        33, 0, 0};

    for (int i = 0; i < 15; i++) do_op(vecs[i], i);
    mhi = vecs[14].hi; mlo = vecs[14].lo;

    // Annulled MULT in IDLE must not write.
    @(negedge clk);
    aluop_i = MULT; reg1_i = 32'd3; reg2_i = 32'd3; ex_adv_i = 1'b1; annul_i = 1'b1;
    sb.push_back({mhi, mlo});
    #1 chk("annul_mult_stall", {63'd0, stallreq_o}, 64'd0);
    @(negedge clk);
    annul_i = 1'b0; ex_adv_i = 1'b0; aluop_i = NOP;
    #1 sb_check("annul_mult_hilo");

    // Annulled DIVU in IDLE must not start.
    @(negedge clk);
    aluop_i = DIVU; reg1_i = 32'd50; reg2_i = 32'd5; annul_i = 1'b1;
    #1 chk("annul_div_idle_stall", {63'd0, stallreq_o}, 64'd0);
    @(negedge clk);
    annul_i = 1'b0; aluop_i = NOP;
    #1 chk("annul_div_idle_busy", {63'd0, busy_o}, 64'd0);

    // Annul at BUSY cycle 10.
    @(negedge clk);
    aluop_i = DIVU; reg1_i = 32'd1000; reg2_i = 32'd3;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    #1;
    chk("annul_busy_stall", {62'd0, stallreq_o, busy_o}, 64'd1);
    @(negedge clk);
    annul_i = 1'b0; aluop_i = NOP;
    #1;
    chk("annul_busy_idle", {62'd0, stallreq_o, busy_o}, 64'd0);
    sb.push_back({mhi, mlo});
    sb_check("annul_busy_hilo");
    repeat (30) @(negedge clk);
    #1 chk("annul_busy_no_late_write", {hi_o, lo_o}, {mhi, mlo});

    // Reset at BUSY cycle 10.
    @(negedge clk);
    aluop_i = DIVU; reg1_i = 32'd1000; reg2_i = 32'd3;
    repeat (10) @(negedge clk);
    rst = 1'b1; annul_i = 1'b1; ex_adv_i = 1'b1;
    #1 chk("rst_busy_outputs", {62'd0, stallreq_o, busy_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0; annul_i = 1'b0; ex_adv_i = 1'b0; aluop_i = NOP;
    #1;
    chk("rst_busy_idle", {62'd0, stallreq_o, busy_o}, 64'd0);
    chk("rst_busy_hilo", {hi_o, lo_o}, 64'd0);
    repeat (30) @(negedge clk);
    #1 chk("rst_no_late_write", {hi_o, lo_o}, 64'd0);

    v = '{DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 33, 0, 0};
    do_op(v, 15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
